bp_btb_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 41 ++++
 rtl/bp_pht.sv | 47 ++++
 rtl/bp_btb_predictor.sv | 143 ++++++++++++++
 tb/tb_bp_btb_predictor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB branch predictor: entry layout,
// counter constants, saturating arithmetic and PC index/tag extraction.
package bp_pkg;

  localparam int BP_MAX_ADDR_W   = 64;
  localparam int BP_MAX_CTR_BITS = 4;

  typedef logic [BP_MAX_CTR_BITS-1:0] ctr_t;

  // Fields are sized for the widest supported address; narrower builds zero-extend.
  typedef struct packed {
    logic                     valid;
    logic [BP_MAX_ADDR_W-1:0] tag;
    logic [BP_MAX_ADDR_W-1:0] target;
  } btb_entry_t;

  function automatic ctr_t ctr_max(input int bits);
    return ctr_t'((1 << bits) - 1);
  endfunction

  function automatic ctr_t ctr_weak_taken(input int bits);
    return ctr_t'(1 << (bits - 1));
  endfunction

  function automatic ctr_t sat_inc(input ctr_t v, input int bits);
    return (v >= ctr_max(bits)) ? v : v + ctr_t'(1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t v);
    return (v == '0) ? v : v - ctr_t'(1);
  endfunction

  function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of saturating direction counters with a
// combinational read port and a registered update/allocate port.
module bp_pht
  import bp_pkg::*;
#(
  parameter  int ENTRIES  = 16,
  parameter  int CTR_BITS = 2,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr,
  input  logic                wr_en,
  input  logic                wr_alloc,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_taken
);

  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  // A fresh allocation starts weakly taken; otherwise the counter moves toward the outcome.
  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_alloc) begin
        ctr_d[wr_idx] = CTR_BITS'(ctr_weak_taken(CTR_BITS));
      end else if (wr_taken) begin
        ctr_d[wr_idx] = CTR_BITS'(sat_inc(ctr_t'(ctr_q[wr_idx]), CTR_BITS));
      end else begin
        ctr_d[wr_idx] = CTR_BITS'(sat_dec(ctr_t'(ctr_q[wr_idx])));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '{default: '0};
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/bp_btb_predictor.sv
// Tagged direct-mapped BTB plus saturating-counter direction predictor with
// mispredict redirect and accuracy statistics. Define BP_GSHARE_EN for gshare indexing.
module bp_btb_predictor
  import bp_pkg::*;
#(
  parameter  int ADDR_W   = 32,
  parameter  int ENTRIES  = 16,
  parameter  int CTR_BITS = 2,
  parameter  int STAT_W   = 32,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              lookup_hit,
  output logic              lookup_taken,
  output logic [ADDR_W-1:0] lookup_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [STAT_W-1:0] stat_correct,
  output logic [STAT_W-1:0] stat_wrong
`ifdef BP_GSHARE_EN
  ,
  output logic [IDX_W-1:0]  lookup_ghr,
  input  logic [IDX_W-1:0]  upd_ghr
`endif
);

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];

  logic [IDX_W-1:0]    lookup_idx, upd_idx;
  logic [63:0]         lookup_tag, upd_tag;
  logic [IDX_W-1:0]    pht_rd_idx, pht_wr_idx;
  logic [CTR_BITS-1:0] pht_rd_ctr;
  logic                upd_accept, upd_hit;
  logic [STAT_W-1:0]   stat_correct_q, stat_correct_d;
  logic [STAT_W-1:0]   stat_wrong_q, stat_wrong_d;

  assign lookup_idx = IDX_W'(pc_idx(64'(lookup_pc), IDX_W));
  assign upd_idx    = IDX_W'(pc_idx(64'(upd_pc), IDX_W));
  assign lookup_tag = pc_tag(64'(lookup_pc), IDX_W);
  assign upd_tag    = pc_tag(64'(upd_pc), IDX_W);
  assign upd_accept = upd_valid && !reset;
  assign upd_hit    = btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  assign lookup_ghr = ghr_q;
  assign pht_rd_idx = lookup_idx ^ ghr_q;
  assign pht_wr_idx = upd_idx ^ upd_ghr;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_accept) begin
      ghr_d = IDX_W'({ghr_q, upd_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign pht_rd_idx = lookup_idx;
  assign pht_wr_idx = upd_idx;
`endif

  bp_pht #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pht_rd_idx),
    .rd_ctr   (pht_rd_ctr),
    .wr_en    (upd_accept && (upd_hit || upd_taken)),
    .wr_alloc (!upd_hit),
    .wr_idx   (pht_wr_idx),
    .wr_taken (upd_taken)
  );

  always_comb begin
    lookup_hit    = btb_q[lookup_idx].valid && (btb_q[lookup_idx].tag == lookup_tag);
    lookup_taken  = lookup_hit && pht_rd_ctr[CTR_BITS-1];
    lookup_target = lookup_hit ? ADDR_W'(btb_q[lookup_idx].target) : '0;
  end

  always_comb begin
    mispredict  = upd_accept &&
                  ((upd_taken != upd_pred_taken) ||
                   (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + ADDR_W'(4);
  end

  // Taken branches refresh the target on a hit and claim the slot on a miss.
  always_comb begin
    btb_d = btb_q;
    if (upd_accept && upd_taken) begin
      btb_d[upd_idx].valid  = 1'b1;
      btb_d[upd_idx].tag    = upd_tag;
      btb_d[upd_idx].target = 64'(upd_target);
    end
  end

  always_comb begin
    stat_correct_d = stat_correct_q;
    stat_wrong_d   = stat_wrong_q;
    if (upd_accept) begin
      if (mispredict) begin
        if (stat_wrong_q != '1) stat_wrong_d = stat_wrong_q + STAT_W'(1);
      end else begin
        if (stat_correct_q != '1) stat_correct_d = stat_correct_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btb_q          <= '{default: '0};
      stat_correct_q <= '0;
      stat_wrong_q   <= '0;
    end else begin
      btb_q          <= btb_d;
      stat_correct_q <= stat_correct_d;
      stat_wrong_q   <= stat_wrong_d;
    end
  end

  assign stat_correct = stat_correct_q;
  assign stat_wrong   = stat_wrong_q;

endmodule

// File: tb/tb_bp_btb_predictor.sv
// Testbench for bp_btb_predictor: directed scenarios then random traffic,
// checked against a table-level reference model through an expectation queue.
module tb_bp_btb_predictor;

   localparam int ADDR_W   = 32;
   localparam int ENTRIES  = 16;
   localparam int CTR_BITS = 2;
   localparam int STAT_W   = 32;
   localparam int IDX_W    = $clog2(ENTRIES);
   localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
   localparam int CTR_HALF = 1 << (CTR_BITS - 1);

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] lookupPc;
   logic              lookupHit, lookupTaken;
   logic [ADDR_W-1:0] lookupTarget;
   logic              updValid, updTaken, updPredTaken;
   logic [ADDR_W-1:0] updPc, updTarget, updPredTarget;
   logic              mispredict;
   logic [ADDR_W-1:0] redirectPc;
   logic [STAT_W-1:0] statCorrect, statWrong;
`ifdef BP_GSHARE_EN
   logic [IDX_W-1:0]  lookupGhr, updGhr;
`endif

   bp_btb_predictor #(
      .ADDR_W   (ADDR_W),
      .ENTRIES  (ENTRIES),
      .CTR_BITS (CTR_BITS),
      .STAT_W   (STAT_W)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .lookup_pc       (lookupPc),
      .lookup_hit      (lookupHit),
      .lookup_taken    (lookupTaken),
      .lookup_target   (lookupTarget),
      .upd_valid       (updValid),
      .upd_pc          (updPc),
      .upd_taken       (updTaken),
      .upd_target      (updTarget),
      .upd_pred_taken  (updPredTaken),
      .upd_pred_target (updPredTarget),
      .mispredict      (mispredict),
      .redirect_pc     (redirectPc),
      .stat_correct    (statCorrect),
      .stat_wrong      (statWrong)
`ifdef BP_GSHARE_EN
      ,
      .lookup_ghr      (lookupGhr),
      .upd_ghr         (updGhr)
`endif
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   typedef struct {
      logic        hit;
      logic        taken;
      logic [31:0] target;
      logic        misp;
      logic [31:0] redir;
      logic [31:0] statC;
      logic [31:0] statW;
      logic [31:0] ghr;
   } expect_t;

   expect_t expQ[$];
   expect_t monExp;
   int assertCount = 0;
   int failCount   = 0;

   // Reference model: plain per-slot arrays indexed by PC arithmetic
   bit              mValid  [ENTRIES];
   longint unsigned mTag    [ENTRIES];
   logic [31:0]     mTarget [ENTRIES];
   int              mCtr    [ENTRIES];
   int              mGhr;
   longint unsigned mCorrect, mWrong;

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic longint unsigned tagOf(input logic [31:0] pc);
      return longint'(pc / (4 * ENTRIES));
   endfunction

   function automatic int ctrIdx(input int idx, input int hist);
`ifdef BP_GSHARE_EN
      return idx ^ (hist % ENTRIES);
`else
      return idx + 0 * hist;
`endif
   endfunction

   function automatic bit modelHit(input logic [31:0] pc);
      return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
   endfunction

   task automatic modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         mValid[i]  = 1'b0;
         mTag[i]    = 0;
         mTarget[i] = '0;
         mCtr[i]    = 0;
      end
      mGhr     = 0;
      mCorrect = 0;
      mWrong   = 0;
   endtask

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input expect_t e);
      checkVal("lookup_hit", 32'(lookupHit), 32'(e.hit));
      checkVal("lookup_taken", 32'(lookupTaken), 32'(e.taken));
      checkVal("lookup_target", lookupTarget, e.target);
      checkVal("mispredict", 32'(mispredict), 32'(e.misp));
      if (e.misp) checkVal("redirect_pc", redirectPc, e.redir);
      checkVal("stat_correct", statCorrect, e.statC);
      checkVal("stat_wrong", statWrong, e.statW);
`ifdef BP_GSHARE_EN
      checkVal("lookup_ghr", 32'(lookupGhr), e.ghr);
`endif
   endtask

   // Drive one cycle of inputs, queue what the outputs must show, then advance the model
   task automatic applyStimulus(input bit rst, input logic [31:0] lpc,
                                input bit uv, input logic [31:0] upc, input bit ut,
                                input logic [31:0] utgt, input bit upt,
                                input logic [31:0] uptgt, input int ughr, input bit track);
      expect_t e;
      int li, ui, uci;
      bit uh;
      @(posedge clk);
      #1;
      reset         = rst;
      lookupPc      = lpc;
      updValid      = uv;
      updPc         = upc;
      updTaken      = ut;
      updTarget     = utgt;
      updPredTaken  = upt;
      updPredTarget = uptgt;
`ifdef BP_GSHARE_EN
      updGhr        = IDX_W'(ughr);
`endif
      li       = idxOf(lpc);
      e.hit    = modelHit(lpc);
      e.taken  = e.hit && (mCtr[ctrIdx(li, mGhr)] >= CTR_HALF);
      e.target = e.hit ? mTarget[li] : 32'h0;
      e.misp   = uv && !rst && ((ut != upt) || (ut && (uptgt != utgt)));
      e.redir  = ut ? utgt : upc + 32'd4;
      e.statC  = 32'(mCorrect);
      e.statW  = 32'(mWrong);
      e.ghr    = 32'(mGhr);
      if (track) expQ.push_back(e);

      if (rst) begin
         modelReset();
      end else if (uv) begin
         ui  = idxOf(upc);
         uci = ctrIdx(ui, ughr);
         uh  = modelHit(upc);
         if (uh) begin
            if (ut) begin
               if (mCtr[uci] < CTR_TOP) mCtr[uci]++;
               mTarget[ui] = utgt;
            end else if (mCtr[uci] > 0) begin
               mCtr[uci]--;
            end
         end else if (ut) begin
            mValid[ui]  = 1'b1;
            mTag[ui]    = tagOf(upc);
            mTarget[ui] = utgt;
            mCtr[uci]   = CTR_HALF;
         end
         mGhr = ((mGhr * 2) + int'(ut)) % ENTRIES;
         if (e.misp) begin
            if (mWrong < 64'hFFFF_FFFF) mWrong++;
         end else begin
            if (mCorrect < 64'hFFFF_FFFF) mCorrect++;
         end
      end
   endtask

   task automatic idleLookup(input logic [31:0] lpc);
      applyStimulus(1'b0, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, mGhr, 1'b1);
   endtask

   task automatic update(input logic [31:0] lpc, input logic [31:0] upc, input bit ut,
                         input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt);
      applyStimulus(1'b0, lpc, 1'b1, upc, ut, utgt, upt, uptgt, mGhr, 1'b1);
   endtask

   function automatic logic [31:0] randPc();
      logic [31:0] hi;
      hi = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
      return (hi << 6) | 32'($urandom_range(0, ENTRIES - 1) << 2) | 32'($urandom_range(0, 3));
   endfunction

   // Monitor: compare the oldest expectation whenever a cycle's outputs are stable
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp = expQ.pop_front();
         checkOutput(monExp);
      end
   end

   // Stimulus: directed scenarios first, then randomized traffic with occasional resets
   initial begin
      logic [31:0] lpc, upc, utgt, ptgt;
      bit ut, uv, upt, rst;
      int li, ghrUse;
      reset = 1'b1; lookupPc = '0; updValid = 1'b0; updPc = '0; updTaken = 1'b0;
      updTarget = '0; updPredTaken = 1'b0; updPredTarget = '0;
`ifdef BP_GSHARE_EN
      updGhr = '0;
`endif
      modelReset();
      applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);
      applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0);

      idleLookup(32'h40);
      update(32'h40, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
      idleLookup(32'h40);
      for (int i = 0; i < 4; i++) update(32'h40, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
      idleLookup(32'h40);
      for (int i = 0; i < 5; i++) update(32'h40, 32'h40, 1'b1, 32'h80, 1'b0, 32'h80);
      update(32'h40, 32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
      idleLookup(32'h40);
      update(32'h40, 32'h40, 1'b1, 32'hC0, 1'b1, 32'hC0);
      update(32'h440, 32'h440, 1'b1, 32'h100, 1'b0, 32'h0);
      idleLookup(32'h40);
      idleLookup(32'h440);
      update(32'h40, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      update(32'h7C, 32'h7C, 1'b0, 32'h0, 1'b1, 32'h0);
      idleLookup(32'h7C);
      update(32'h43, 32'h43, 1'b1, 32'h200, 1'b0, 32'h0);
      idleLookup(32'h41);
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h0, mGhr, 1'b1);
      idleLookup(32'h40);

      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 199) == 0);
         lpc  = randPc();
         uv   = ($urandom_range(0, 3) != 0);
         upc  = ($urandom_range(0, 1) == 0) ? lpc : randPc();
         ut   = $urandom_range(0, 1);
         utgt = 32'($urandom_range(0, 7)) << 6;
         li   = idxOf(upc);
         ghrUse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ENTRIES - 1)) : mGhr;
         if ($urandom_range(0, 1) == 0) begin
            upt  = modelHit(upc) && (mCtr[ctrIdx(li, ghrUse)] >= CTR_HALF);
            ptgt = modelHit(upc) ? mTarget[li] : 32'h0;
         end else begin
            upt  = $urandom_range(0, 1);
            ptgt = ($urandom_range(0, 1) == 0) ? utgt : 32'($urandom_range(0, 7)) << 6;
         end
         applyStimulus(rst, lpc, uv, upc, ut, utgt, upt, ptgt, ghrUse, 1'b1);
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      checkVal("queue_drained", 32'(expQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
